mem_port_arbiter: RTL and testbench

- Shares one unified memory port between the core's instruction-fetch requester (IF) and data load/store requester (DM).
- Sits between the PC/instruction path, the ALU-address/data-memory path, and a single backing memory with variable ack latency.
- Latches each granted request, holds it on the memory side until acknowledged or timed out, then returns a registered response to the owner.

---
 rtl/mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch (IF)
// and data load/store (DM) requesters. One access is outstanding at a time.
// Each access is held on the memory side until it is acknowledged or times out.
// Optional feature macro: FAIR_RR_EN. When defined, contested grants
// alternate using a last-granted pointer. When undefined, DM beats IF.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_IfReq,
  input  logic [ADDR_W-1:0]     i_IfAddr,
  output logic                  o_IfGnt,
  output logic                  o_IfValid,
  output logic [DATA_W-1:0]     o_IfRdata,
  output logic                  o_IfErr,
  input  logic                  i_DmReq,
  input  logic                  i_DmWe,
  input  logic [ADDR_W-1:0]     i_DmAddr,
  input  logic [DATA_W-1:0]     i_DmWdata,
  input  logic [DATA_W/8-1:0]   i_DmStrb,
  output logic                  o_DmGnt,
  output logic                  o_DmValid,
  output logic [DATA_W-1:0]     o_DmRdata,
  output logic                  o_DmErr,
  output logic                  o_MemReq,
  output logic                  o_MemWe,
  output logic [ADDR_W-1:0]     o_MemAddr,
  output logic [DATA_W-1:0]     o_MemWdata,
  output logic [DATA_W/8-1:0]   o_MemStrb,
  input  logic                  i_MemAck,
  input  logic [DATA_W-1:0]     i_MemRdata,
  output logic                  o_Busy
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 16;
  // Counter value at which a further cycle without ack aborts the access
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_strb_q,  mem_strb_d;
  logic                if_gnt_q,    if_gnt_d;
  logic                if_valid_q,  if_valid_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic                if_err_q,    if_err_d;
  logic                dm_gnt_q,    dm_gnt_d;
  logic                dm_valid_q,  dm_valid_d;
  logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
  logic                dm_err_q,    dm_err_d;
  logic                busy_q;

  logic                dm_first;
  logic                take_dm;
  logic                take_if;
  logic                ack;

`ifdef FAIR_RR_EN
  // Last-granted pointer: 1 = DM was granted last, 0 = IF
  logic rr_last_dm_q, rr_last_dm_d;

  // DM wins a contested grant only when IF was granted last
  assign dm_first = ~rr_last_dm_q;

  // Pointer follows every grant, contested or not
  always_comb begin
    rr_last_dm_d = rr_last_dm_q;
    if (take_dm) begin
      rr_last_dm_d = 1'b1;
    end else if (take_if) begin
      rr_last_dm_d = 1'b0;
    end
  end

  // Pointer register
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      rr_last_dm_q <= 1'b0;
    end else begin
      rr_last_dm_q <= rr_last_dm_d;
    end
  end
`else
  // Fixed priority: data accesses beat fetches
  assign dm_first = 1'b1;
`endif

  // Arbitration is only meaningful while the port is free
  assign take_dm = (state_q == IDLE) & i_DmReq & (~i_IfReq | dm_first);
  assign take_if = (state_q == IDLE) & i_IfReq & ~take_dm;

  // Ack is only honoured while a request is being presented
  assign ack = i_MemAck & mem_req_q;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_strb_d  = mem_strb_q;
    if_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_gnt_d    = 1'b0;
    dm_valid_d  = 1'b0;
    dm_err_d    = 1'b0;
    dm_rdata_d  = dm_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (take_dm) begin
          state_d     = DM_BUSY;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = i_DmWe;
          mem_addr_d  = i_DmAddr;
          mem_wdata_d = i_DmWdata;
          // Byte enables only mean something for stores
          mem_strb_d  = i_DmWe ? i_DmStrb : '0;
          dm_gnt_d    = 1'b1;
        end else if (take_if) begin
          state_d     = IF_BUSY;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_IfAddr;
          mem_wdata_d = '0;
          mem_strb_d  = '0;
          if_gnt_d    = 1'b1;
        end
      end

      IF_BUSY, DM_BUSY: begin
        // An ack in the expiry cycle still counts as a normal completion
        if (ack || (cnt_q == CNT_LAST)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          mem_req_d = 1'b0;
          if (state_q == IF_BUSY) begin
            if_valid_d = 1'b1;
            if_err_d   = ~ack;
            if (ack) begin
              if_rdata_d = i_MemRdata;
            end
          end else begin
            dm_valid_d = 1'b1;
            dm_err_d   = ~ack;
            if (ack && !mem_we_q) begin
              dm_rdata_d = i_MemRdata;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access silently
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_strb_q  <= '0;
      if_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      dm_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
      dm_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_strb_q  <= mem_strb_d;
      if_gnt_q    <= if_gnt_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      dm_gnt_q    <= dm_gnt_d;
      dm_valid_q  <= dm_valid_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_err_q    <= dm_err_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign o_IfGnt    = if_gnt_q;
  assign o_IfValid  = if_valid_q;
  assign o_IfRdata  = if_rdata_q;
  assign o_IfErr    = if_err_q;
  assign o_DmGnt    = dm_gnt_q;
  assign o_DmValid  = dm_valid_q;
  assign o_DmRdata  = dm_rdata_q;
  assign o_DmErr    = dm_err_q;
  assign o_MemReq   = mem_req_q;
  assign o_MemWe    = mem_we_q;
  assign o_MemAddr  = mem_addr_q;
  assign o_MemWdata = mem_wdata_q;
  assign o_MemStrb  = mem_strb_q;
  assign o_Busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// transactions, all checked against a transaction-level model of the port.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;
  localparam int TO = 4;

  logic          i_Clock;
  logic          i_Reset;
  logic          i_IfReq;
  logic [AW-1:0] i_IfAddr;
  logic          o_IfGnt;
  logic          o_IfValid;
  logic [DW-1:0] o_IfRdata;
  logic          o_IfErr;
  logic          i_DmReq;
  logic          i_DmWe;
  logic [AW-1:0] i_DmAddr;
  logic [DW-1:0] i_DmWdata;
  logic [SW-1:0] i_DmStrb;
  logic          o_DmGnt;
  logic          o_DmValid;
  logic [DW-1:0] o_DmRdata;
  logic          o_DmErr;
  logic          o_MemReq;
  logic          o_MemWe;
  logic [AW-1:0] o_MemAddr;
  logic [DW-1:0] o_MemWdata;
  logic [SW-1:0] o_MemStrb;
  logic          i_MemAck;
  logic [DW-1:0] i_MemRdata;
  logic          o_Busy;

  int total = 0;
  int bad   = 0;

  // Model state: last data returned to each requester
  logic [63:0] exp_if_rdata = 64'h0;
  logic [63:0] exp_dm_rdata = 64'h0;
`ifdef FAIR_RR_EN
  bit last_dm = 1'b0;
`endif

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_IfReq   (i_IfReq),
    .i_IfAddr  (i_IfAddr),
    .o_IfGnt   (o_IfGnt),
    .o_IfValid (o_IfValid),
    .o_IfRdata (o_IfRdata),
    .o_IfErr   (o_IfErr),
    .i_DmReq   (i_DmReq),
    .i_DmWe    (i_DmWe),
    .i_DmAddr  (i_DmAddr),
    .i_DmWdata (i_DmWdata),
    .i_DmStrb  (i_DmStrb),
    .o_DmGnt   (o_DmGnt),
    .o_DmValid (o_DmValid),
    .o_DmRdata (o_DmRdata),
    .o_DmErr   (o_DmErr),
    .o_MemReq  (o_MemReq),
    .o_MemWe   (o_MemWe),
    .o_MemAddr (o_MemAddr),
    .o_MemWdata(o_MemWdata),
    .o_MemStrb (o_MemStrb),
    .i_MemAck  (i_MemAck),
    .i_MemRdata(i_MemRdata),
    .o_Busy    (o_Busy)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  function automatic bit dm_wins();
`ifdef FAIR_RR_EN
    return !last_dm;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_mem_req"}, o_MemReq, 1'b0);
    chk1({tag, "_busy"}, o_Busy, 1'b0);
    chk1({tag, "_mem_we"}, o_MemWe, 1'b0);
    chk({tag, "_mem_addr"}, o_MemAddr, 64'h0);
    chk({tag, "_mem_wdata"}, o_MemWdata, 64'h0);
    chk({tag, "_mem_strb"}, 64'(o_MemStrb), 64'h0);
    chk1({tag, "_if_gnt"}, o_IfGnt, 1'b0);
    chk1({tag, "_dm_gnt"}, o_DmGnt, 1'b0);
    chk1({tag, "_if_valid"}, o_IfValid, 1'b0);
    chk1({tag, "_dm_valid"}, o_DmValid, 1'b0);
    chk1({tag, "_if_err"}, o_IfErr, 1'b0);
    chk1({tag, "_dm_err"}, o_DmErr, 1'b0);
    chk({tag, "_if_rdata"}, o_IfRdata, 64'h0);
    chk({tag, "_dm_rdata"}, o_DmRdata, 64'h0);
  endtask

  // Present one or two requests together and act as the memory for each
  // served access. d = wait cycles before ack (d >= TO means no ack).
  task automatic run_txn(input bit w_if, input bit w_dm, input bit we,
                         input logic [63:0] ia, input logic [63:0] da,
                         input logic [63:0] wd, input logic [7:0] st,
                         input int d1, input int d2,
                         input logic [63:0] r1, input logic [63:0] r2);
    bit          dm_first, sv_dm, tmo, ewe;
    int          n, d;
    logic [63:0] r, ea;
    logic [7:0]  est;
    n        = int'(w_if) + int'(w_dm);
    dm_first = w_dm && (!w_if || dm_wins());
    i_IfReq   = w_if;
    i_IfAddr  = ia;
    i_DmReq   = w_dm;
    i_DmWe    = we;
    i_DmAddr  = da;
    i_DmWdata = wd;
    i_DmStrb  = st;
    for (int s = 0; s < n; s++) begin
      sv_dm = (s == 0) ? dm_first : !dm_first;
      d     = (s == 0) ? d1 : d2;
      r     = (s == 0) ? r1 : r2;
      ea    = sv_dm ? da : ia;
      ewe   = sv_dm && we;
      est   = ewe ? st : 8'h00;
      step();
      chk1("if_gnt", o_IfGnt, !sv_dm);
      chk1("dm_gnt", o_DmGnt, sv_dm);
      if (sv_dm) i_DmReq = 1'b0;
      else       i_IfReq = 1'b0;
`ifdef FAIR_RR_EN
      last_dm = sv_dm;
`endif
      tmo = 1'b1;
      for (int k = 0; k < TO; k++) begin
        chk1("mem_req_held", o_MemReq, 1'b1);
        chk1("busy_held", o_Busy, 1'b1);
        chk("mem_addr", o_MemAddr, ea);
        chk1("mem_we", o_MemWe, ewe);
        chk("mem_strb", 64'(o_MemStrb), 64'(est));
        if (sv_dm) chk("mem_wdata", o_MemWdata, wd);
        chk1("if_valid_early", o_IfValid, 1'b0);
        chk1("dm_valid_early", o_DmValid, 1'b0);
        if (k > 0) begin
          chk1("if_gnt_extra", o_IfGnt, 1'b0);
          chk1("dm_gnt_extra", o_DmGnt, 1'b0);
        end
        i_MemAck   = (k == d);
        i_MemRdata = r;
        step();
        if (k == d) begin
          tmo = 1'b0;
          break;
        end
      end
      if (!tmo && !ewe) begin
        if (sv_dm) exp_dm_rdata = r;
        else       exp_if_rdata = r;
      end
      chk1("if_valid", o_IfValid, !sv_dm);
      chk1("dm_valid", o_DmValid, sv_dm);
      chk1("if_err", o_IfErr, !sv_dm && tmo);
      chk1("dm_err", o_DmErr, sv_dm && tmo);
      chk("if_rdata", o_IfRdata, exp_if_rdata);
      chk("dm_rdata", o_DmRdata, exp_dm_rdata);
      chk1("mem_req_drop", o_MemReq, 1'b0);
      chk1("busy_drop", o_Busy, 1'b0);
      chk1("if_gnt_on_valid", o_IfGnt, 1'b0);
      chk1("dm_gnt_on_valid", o_DmGnt, 1'b0);
      i_MemAck = 1'b0;
    end
  endtask

  initial begin
    i_Reset    = 1'b0;
    i_IfReq    = 1'b0;
    i_IfAddr   = '0;
    i_DmReq    = 1'b0;
    i_DmWe     = 1'b0;
    i_DmAddr   = '0;
    i_DmWdata  = '0;
    i_DmStrb   = '0;
    i_MemAck   = 1'b0;
    i_MemRdata = '0;
    #2;
    chk_all_zero("reset");
    #1 i_Reset = 1'b1;

    // Zero-wait fetch
    run_txn(1'b1, 1'b0, 1'b0, 64'h1000, 64'h0, 64'h0, 8'h00, 0, 0,
            64'h00000013_00000093, 64'h0);

    // Contested fetch and load, 3 wait states each
    run_txn(1'b1, 1'b1, 1'b0, 64'h2000, 64'h8000, 64'h0, 8'hFF, 3, 3,
            64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);

    // Store keeps the previous load data
    run_txn(1'b0, 1'b1, 1'b1, 64'h0, 64'h40, 64'hDEADBEEF_CAFEF00D, 8'h0F, 2, 0,
            64'hBAD0_BAD0_BAD0_BAD0, 64'h0);

    // Load that is never acked, then a normal fetch
    run_txn(1'b0, 1'b1, 1'b0, 64'h0, 64'h8008, 64'h0, 8'hAA, 1000, 0,
            64'hFFFF_0000_FFFF_0000, 64'h0);
    run_txn(1'b1, 1'b0, 1'b0, 64'h3000, 64'h0, 64'h0, 8'h00, 1, 0,
            64'hA5A5_5A5A_0102_0304, 64'h0);

    // Ack exactly in the expiry cycle
    run_txn(1'b0, 1'b1, 1'b0, 64'h0, 64'h9000, 64'h0, 8'h00, TO - 1, 0,
            64'h0BAD_F00D_1234_5678, 64'h0);

    // Reset in the middle of a load
    i_DmReq  = 1'b1;
    i_DmWe   = 1'b0;
    i_DmAddr = 64'h8000;
    i_MemAck = 1'b0;
    step();
    chk1("pre_rst_dm_gnt", o_DmGnt, 1'b1);
    i_DmReq = 1'b0;
    step();
    step();
    chk1("pre_rst_mem_req", o_MemReq, 1'b1);
    i_Reset = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    #2 i_Reset = 1'b1;
    exp_if_rdata = 64'h0;
    exp_dm_rdata = 64'h0;
`ifdef FAIR_RR_EN
    last_dm = 1'b0;
`endif
    for (int c = 0; c < 3; c++) begin
      step();
      chk1("post_rst_if_valid", o_IfValid, 1'b0);
      chk1("post_rst_dm_valid", o_DmValid, 1'b0);
      chk1("post_rst_mem_req", o_MemReq, 1'b0);
    end
    run_txn(1'b1, 1'b0, 1'b0, 64'h4000, 64'h0, 64'h0, 8'h00, 0, 0,
            64'h7777_8888_9999_AAAA, 64'h0);

    // Randomized traffic with idle gaps and stray acks while idle
    for (int t = 0; t < 40; t++) begin
      bit w_if, w_dm;
      int n_idle;
      n_idle = int'($urandom_range(0, 2));
      for (int c = 0; c < n_idle; c++) begin
        i_MemAck   = 1'($urandom_range(0, 1));
        i_MemRdata = {$urandom, $urandom};
        step();
        chk1("idle_mem_req", o_MemReq, 1'b0);
        chk1("idle_busy", o_Busy, 1'b0);
        chk1("idle_if_valid", o_IfValid, 1'b0);
        chk1("idle_dm_valid", o_DmValid, 1'b0);
        chk("idle_if_rdata", o_IfRdata, exp_if_rdata);
        chk("idle_dm_rdata", o_DmRdata, exp_dm_rdata);
      end
      w_if = 1'($urandom_range(0, 1));
      w_dm = 1'($urandom_range(0, 1));
      if (!w_if && !w_dm) w_if = 1'b1;
      run_txn(w_if, w_dm, 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              8'($urandom), int'($urandom_range(0, TO + 1)),
              int'($urandom_range(0, TO + 1)),
              {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
